// File: rtl/watch_pkg.sv
// Shared definitions for the watch timekeeper: FSM state encodings, field
// limits, field-select enum and a wrap-around step helper.
package watch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_SET_SEC  = 3'b001,
        ST_SET_MIN  = 3'b010,
        ST_SET_HOUR = 3'b100
    } watch_state_t;

    typedef enum logic [1:0] {
        FIELD_NONE,
        FIELD_SEC,
        FIELD_MIN,
        FIELD_HOUR
    } field_sel_t;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    // +/-1 on a 0..maxv field with wrap in both directions, no carry out.
    function automatic logic [5:0] wrap_step(input logic [5:0] v,
                                             input logic [5:0] maxv,
                                             input logic       up);
        if (up)
            return (v == maxv) ? 6'd0 : v + 6'd1;
        else
            return (v == 6'd0) ? maxv : v - 6'd1;
    endfunction

endpackage

// File: rtl/watch_tick_gen.sv
// Sub-second tick divider: one-cycle tick every CLK_FREQ_HZ/TICK_HZ clocks.
// clr restarts the period and suppresses a tick in the same cycle.
module watch_tick_gen #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          at_end;

    assign at_end = (cnt == CW'(DIV - 1));
    assign tick   = at_end && !clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr || at_end)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/watch_timekeeper.sv
// Wristwatch timekeeper with set mode, button auto-repeat and 12/24h display.
// Optional alarm comparator is built when WATCH_ALARM_EN is defined.
module watch_timekeeper
    import watch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100,
    parameter int INIT_HOUR   = 12,
    parameter int RPT_DELAY   = 50,
    parameter int RPT_RATE    = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_btnL,
    input  logic        i_btnR,
    input  logic        i_btnU,
    input  logic        i_btnD,
    input  logic        i_set_mode_command,
    input  logic        i_display_switch,
    input  logic        i_hour12,
    output logic [13:0] watch_data,
    output logic [6:0]  msec,
    output logic [2:0]  watch_state,
    output logic        o_pm
`ifdef WATCH_ALARM_EN
   ,input  logic        i_alarm_arm,
    input  logic [4:0]  i_alarm_hour,
    input  logic [5:0]  i_alarm_min,
    output logic        o_alarm
`endif
);

    localparam int RW = (RPT_DELAY > 1) ? $clog2(RPT_DELAY) : 1;

    watch_state_t  state, next_state;
    field_sel_t    field_sel;
    logic [5:0]    sec, min;
    logic [4:0]    hour, disp_hour, hour_step;
    logic [5:0]    sec_step, min_step;
    logic          tick, tick_clr, in_set, enter_set, leave_set;
    logic          mv_l, mv_r;
    logic          u_prev, d_prev, u_edge, d_edge, held;
    logic          rpt_fire, do_step, step_up;
    logic [RW-1:0] rpt_cnt, rpt_cnt_next;

    assign in_set    = (state != ST_IDLE);
    assign enter_set = !in_set && i_set_mode_command;
    assign leave_set = in_set && !i_set_mode_command;
    assign tick_clr  = enter_set || leave_set;

    watch_tick_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .TICK_HZ    (TICK_HZ)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .tick(tick)
    );

    assign mv_l = i_btnL && !i_btnR;
    assign mv_r = i_btnR && !i_btnL;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Dropping the set-mode request wins over any field-select button.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (i_set_mode_command) next_state = ST_SET_SEC;
            ST_SET_SEC:  if (!i_set_mode_command) next_state = ST_IDLE;
                         else if (mv_l) next_state = ST_SET_MIN;
                         else if (mv_r) next_state = ST_SET_HOUR;
            ST_SET_MIN:  if (!i_set_mode_command) next_state = ST_IDLE;
                         else if (mv_l) next_state = ST_SET_HOUR;
                         else if (mv_r) next_state = ST_SET_SEC;
            ST_SET_HOUR: if (!i_set_mode_command) next_state = ST_IDLE;
                         else if (mv_l) next_state = ST_SET_SEC;
                         else if (mv_r) next_state = ST_SET_MIN;
            default:     next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        field_sel = FIELD_NONE;
        case (state)
            ST_SET_SEC:  field_sel = FIELD_SEC;
            ST_SET_MIN:  field_sel = FIELD_MIN;
            ST_SET_HOUR: field_sel = FIELD_HOUR;
            default:     field_sel = FIELD_NONE;
        endcase
    end

    assign u_edge  = i_btnU && !u_prev;
    assign d_edge  = i_btnD && !d_prev;
    assign held    = i_btnU ^ i_btnD;
    assign step_up = i_btnU;

    // After the first step, the counter reloads so later steps come RPT_RATE ticks apart.
    always_comb begin
        rpt_fire     = 1'b0;
        rpt_cnt_next = rpt_cnt;
        if (!in_set || leave_set || !held || u_edge || d_edge) begin
            rpt_cnt_next = '0;
        end else if (tick) begin
            if (rpt_cnt == RW'(RPT_DELAY - 1)) begin
                rpt_fire     = 1'b1;
                rpt_cnt_next = RW'(RPT_DELAY - RPT_RATE);
            end else begin
                rpt_cnt_next = rpt_cnt + RW'(1);
            end
        end
    end

    assign do_step = in_set && !leave_set && held && (u_edge || d_edge || rpt_fire);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            u_prev  <= 1'b0;
            d_prev  <= 1'b0;
            rpt_cnt <= '0;
        end else begin
            u_prev  <= i_btnU;
            d_prev  <= i_btnD;
            rpt_cnt <= rpt_cnt_next;
        end
    end

    assign sec_step  = wrap_step(sec, SEC_MAX, step_up);
    assign min_step  = wrap_step(min, MIN_MAX, step_up);
    assign hour_step = step_up ? ((hour == HOUR_MAX) ? 5'd0 : hour + 5'd1)
                               : ((hour == 5'd0) ? HOUR_MAX : hour - 5'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msec <= '0;
            sec  <= '0;
            min  <= '0;
            hour <= 5'(INIT_HOUR);
        end else if (enter_set || in_set) begin
            msec <= '0;
            if (do_step) begin
                case (field_sel)
                    FIELD_SEC:  sec  <= sec_step;
                    FIELD_MIN:  min  <= min_step;
                    FIELD_HOUR: hour <= hour_step;
                    default:    ;
                endcase
            end
        end else if (tick) begin
            if (msec == 7'(TICK_HZ - 1)) begin
                msec <= '0;
                if (sec == SEC_MAX) begin
                    sec <= '0;
                    if (min == MIN_MAX) begin
                        min  <= '0;
                        hour <= (hour == HOUR_MAX) ? 5'd0 : hour + 5'd1;
                    end else begin
                        min <= min + 6'd1;
                    end
                end else begin
                    sec <= sec + 6'd1;
                end
            end else begin
                msec <= msec + 7'd1;
            end
        end
    end

    always_comb begin
        disp_hour = hour;
        if (i_hour12) begin
            if (hour == 5'd0 || hour == 5'd12)
                disp_hour = 5'd12;
            else if (hour > 5'd12)
                disp_hour = hour - 5'd12;
        end
    end

    assign watch_data  = i_display_switch ? (14'(sec) * 14'd100 + 14'(msec))
                                          : (14'(disp_hour) * 14'd100 + 14'(min));
    assign watch_state = state;
    assign o_pm        = (hour >= 5'd12);

`ifdef WATCH_ALARM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            o_alarm <= 1'b0;
        else
            o_alarm <= i_alarm_arm && (state == ST_IDLE) &&
                       (hour == i_alarm_hour) && (min == i_alarm_min);
    end
`endif

endmodule

// File: tb/tb_watch_timekeeper.sv
// Directed bench for watch_timekeeper at 1 kHz clock / 100 Hz tick; expectations
// go through a scoreboard queue and are checked with immediate assertions.
module tb_watch_timekeeper;

    localparam int SIG_DATA  = 0;
    localparam int SIG_MSEC  = 1;
    localparam int SIG_STATE = 2;
    localparam int SIG_PM    = 3;
    localparam int SIG_ALARM = 4;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_U = 2;
    localparam int BTN_D = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
    logic        set_mode = 1'b0;
    logic        display_switch = 1'b0;
    logic        hour12 = 1'b0;
    logic [13:0] watch_data;
    logic [6:0]  msec;
    logic [2:0]  watch_state;
    logic        o_pm;
`ifdef WATCH_ALARM_EN
    logic        alarm_arm = 1'b0;
    logic [4:0]  alarm_hour = 5'd0;
    logic [5:0]  alarm_min = 6'd0;
    logic        o_alarm;
`endif

    always #5 clk = ~clk;

    watch_timekeeper #(
        .CLK_FREQ_HZ(1000),
        .TICK_HZ    (100)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_btnL            (btn_l),
        .i_btnR            (btn_r),
        .i_btnU            (btn_u),
        .i_btnD            (btn_d),
        .i_set_mode_command(set_mode),
        .i_display_switch  (display_switch),
        .i_hour12          (hour12),
        .watch_data        (watch_data),
        .msec              (msec),
        .watch_state       (watch_state),
        .o_pm              (o_pm)
`ifdef WATCH_ALARM_EN
       ,.i_alarm_arm       (alarm_arm),
        .i_alarm_hour      (alarm_hour),
        .i_alarm_min       (alarm_min),
        .o_alarm           (o_alarm)
`endif
    );

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   assertions_evaluated = 0;
    int   failures = 0;

    function automatic logic [31:0] observe(input int sig);
        logic [31:0] v;
        v = '0;
        case (sig)
            SIG_DATA:  v = 32'(watch_data);
            SIG_MSEC:  v = 32'(msec);
            SIG_STATE: v = 32'(watch_state);
            SIG_PM:    v = 32'(o_pm);
`ifdef WATCH_ALARM_EN
            SIG_ALARM: v = 32'(o_alarm);
`endif
            default:   v = 32'hDEAD_BEEF;
        endcase
        return v;
    endfunction

    task automatic push_exp(input string tag, input int sig, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.sig   = sig;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sig);
            assertions_evaluated++;
            assert (obs === e.value) else begin
                failures++;
                $error("[TB] FAIL %s: observed %0d expected %0d", e.tag, obs, e.value);
            end
        end
    endtask

    task automatic pulse(input int which);
        case (which)
            BTN_L:   btn_l = 1'b1;
            BTN_R:   btn_r = 1'b1;
            BTN_U:   btn_u = 1'b1;
            default: btn_d = 1'b1;
        endcase
        applyStimulus(1);
        btn_l = 1'b0;
        btn_r = 1'b0;
        btn_u = 1'b0;
        btn_d = 1'b0;
        applyStimulus(1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(3);
        push_exp("reset_data", SIG_DATA, 1200);
        push_exp("reset_state", SIG_STATE, 0);
        push_exp("reset_msec", SIG_MSEC, 0);
        push_exp("reset_pm", SIG_PM, 1);
        checkOutput();

        display_switch = 1'b1;
        rst = 1'b1;
        applyStimulus(9);
        push_exp("tick_before_first", SIG_MSEC, 0);
        checkOutput();
        applyStimulus(1);
        push_exp("tick_first_msec", SIG_MSEC, 1);
        push_exp("tick_first_data", SIG_DATA, 1);
        checkOutput();

        // Preload 23:59:59 through set mode
        set_mode = 1'b1;
        applyStimulus(1);
        push_exp("enter_set_state", SIG_STATE, 1);
        push_exp("enter_set_msec", SIG_MSEC, 0);
        checkOutput();
        pulse(BTN_D);
        push_exp("sec_down_wrap", SIG_DATA, 5900);
        checkOutput();
        pulse(BTN_L);
        push_exp("sel_min", SIG_STATE, 2);
        checkOutput();
        display_switch = 1'b0;
        pulse(BTN_D);
        push_exp("min_down_wrap", SIG_DATA, 1259);
        checkOutput();
        pulse(BTN_L);
        push_exp("sel_hour", SIG_STATE, 4);
        checkOutput();
        repeat (11) pulse(BTN_U);
        push_exp("hour_23", SIG_DATA, 2359);
        push_exp("hour_23_pm", SIG_PM, 1);
        checkOutput();
        pulse(BTN_R);
        push_exp("r_hour_to_min", SIG_STATE, 2);
        checkOutput();
        pulse(BTN_L);
        push_exp("l_min_to_hour", SIG_STATE, 4);
        checkOutput();
        btn_l = 1'b1;
        btn_r = 1'b1;
        applyStimulus(1);
        btn_l = 1'b0;
        btn_r = 1'b0;
        push_exp("lr_same_cycle", SIG_STATE, 4);
        checkOutput();

        // Count out 99 ticks, then the midnight rollover tick
        set_mode = 1'b0;
        display_switch = 1'b1;
        applyStimulus(1);
        push_exp("leave_set_state", SIG_STATE, 0);
        checkOutput();
        applyStimulus(990);
        push_exp("pre_roll_msec", SIG_MSEC, 99);
        push_exp("pre_roll_data", SIG_DATA, 5999);
        push_exp("pre_roll_pm", SIG_PM, 1);
        checkOutput();
        applyStimulus(10);
        push_exp("roll_msec", SIG_MSEC, 0);
        push_exp("roll_sec_view", SIG_DATA, 0);
        push_exp("roll_pm", SIG_PM, 0);
        checkOutput();
        display_switch = 1'b0;
        push_exp("roll_hm_view", SIG_DATA, 0);
        checkOutput();
        hour12 = 1'b1;
        push_exp("h12_midnight", SIG_DATA, 1200);
        push_exp("h12_midnight_pm", SIG_PM, 0);
        checkOutput();

        // hour 13 in 12h and 24h display
        set_mode = 1'b1;
        applyStimulus(1);
        pulse(BTN_L);
        pulse(BTN_L);
        push_exp("sel_hour_again", SIG_STATE, 4);
        checkOutput();
        repeat (13) pulse(BTN_U);
        push_exp("h12_hour13", SIG_DATA, 100);
        push_exp("h12_hour13_pm", SIG_PM, 1);
        checkOutput();
        hour12 = 1'b0;
        push_exp("h24_hour13", SIG_DATA, 1300);
        checkOutput();

        // Re-enter set mode to align the divider, then hold U on minutes
        set_mode = 1'b0;
        applyStimulus(1);
        set_mode = 1'b1;
        applyStimulus(1);
        btn_l = 1'b1;
        applyStimulus(1);
        btn_l = 1'b0;
        applyStimulus(1);
        push_exp("rpt_sel_min", SIG_STATE, 2);
        checkOutput();
        btn_u = 1'b1;
        applyStimulus(1);
        push_exp("rpt_edge_step", SIG_DATA, 1301);
        checkOutput();
        applyStimulus(496);
        push_exp("rpt_before_50", SIG_DATA, 1301);
        checkOutput();
        applyStimulus(1);
        push_exp("rpt_at_50", SIG_DATA, 1302);
        checkOutput();
        applyStimulus(99);
        push_exp("rpt_before_60", SIG_DATA, 1302);
        checkOutput();
        applyStimulus(1);
        push_exp("rpt_at_60", SIG_DATA, 1303);
        checkOutput();
        applyStimulus(99);
        push_exp("rpt_before_70", SIG_DATA, 1303);
        checkOutput();
        btn_u = 1'b0;
        applyStimulus(6);
        push_exp("rpt_released", SIG_DATA, 1303);
        checkOutput();

        // Seconds wrap without carry; U and D together do nothing
        pulse(BTN_R);
        push_exp("r_min_to_sec", SIG_STATE, 1);
        checkOutput();
        display_switch = 1'b1;
        pulse(BTN_D);
        push_exp("sec_59", SIG_DATA, 5900);
        checkOutput();
        pulse(BTN_U);
        push_exp("sec_up_wrap", SIG_DATA, 0);
        checkOutput();
        display_switch = 1'b0;
        push_exp("sec_wrap_no_carry", SIG_DATA, 1303);
        checkOutput();
        display_switch = 1'b1;
        btn_u = 1'b1;
        btn_d = 1'b1;
        applyStimulus(2);
        btn_u = 1'b0;
        btn_d = 1'b0;
        applyStimulus(1);
        push_exp("u_and_d_no_step", SIG_DATA, 0);
        checkOutput();

        // Counting resumes a full tick period after leaving set mode
        set_mode = 1'b0;
        applyStimulus(1);
        push_exp("leave_again_state", SIG_STATE, 0);
        checkOutput();
        applyStimulus(9);
        push_exp("resume_before_tick", SIG_MSEC, 0);
        checkOutput();
        applyStimulus(1);
        push_exp("resume_first_tick", SIG_MSEC, 1);
        checkOutput();

        // Reset during an auto-repeat hold
        display_switch = 1'b0;
        set_mode = 1'b1;
        applyStimulus(1);
        btn_u = 1'b1;
        applyStimulus(200);
        rst = 1'b0;
        push_exp("mid_rpt_reset_state", SIG_STATE, 0);
        push_exp("mid_rpt_reset_data", SIG_DATA, 1200);
        checkOutput();
        btn_u = 1'b0;
        set_mode = 1'b0;
        applyStimulus(2);
        rst = 1'b1;
        applyStimulus(2);
        push_exp("post_reset_data", SIG_DATA, 1200);
        push_exp("post_reset_state", SIG_STATE, 0);
        checkOutput();

`ifdef WATCH_ALARM_EN
        set_mode = 1'b1;
        applyStimulus(1);
        pulse(BTN_L);
        pulse(BTN_L);
        repeat (5) pulse(BTN_D);
        pulse(BTN_R);
        repeat (30) pulse(BTN_U);
        push_exp("alarm_time_set", SIG_DATA, 730);
        alarm_hour = 5'd7;
        alarm_min  = 6'd30;
        alarm_arm  = 1'b1;
        applyStimulus(1);
        push_exp("alarm_quiet_in_set", SIG_ALARM, 0);
        checkOutput();
        set_mode = 1'b0;
        applyStimulus(2);
        push_exp("alarm_fires", SIG_ALARM, 1);
        checkOutput();
        alarm_arm = 1'b0;
        applyStimulus(2);
        push_exp("alarm_disarmed", SIG_ALARM, 0);
        checkOutput();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions_evaluated, failures);
        $finish;
    end

endmodule
